// File: rtl/keypad_pkg.sv
// Purpose : shared types and constants for the keypad responder slice.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: FSM state enum, key position struct, key->{row,col} lookup,
//           LFSR seed/taps and the idle column level.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_BOUNCE,
    ST_HOLD,
    ST_REL_BOUNCE,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // x^8+x^6+x^5+x^4+1 on a left-shifting register: taps at bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [3:0] COLS_IDLE = 4'b1111;

  // Layout: row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = E 0 F D.
  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t pos;
    case (key)
      4'h1: pos = '{row: 2'd0, col: 2'd0};
      4'h2: pos = '{row: 2'd0, col: 2'd1};
      4'h3: pos = '{row: 2'd0, col: 2'd2};
      4'hA: pos = '{row: 2'd0, col: 2'd3};
      4'h4: pos = '{row: 2'd1, col: 2'd0};
      4'h5: pos = '{row: 2'd1, col: 2'd1};
      4'h6: pos = '{row: 2'd1, col: 2'd2};
      4'hB: pos = '{row: 2'd1, col: 2'd3};
      4'h7: pos = '{row: 2'd2, col: 2'd0};
      4'h8: pos = '{row: 2'd2, col: 2'd1};
      4'h9: pos = '{row: 2'd2, col: 2'd2};
      4'hC: pos = '{row: 2'd2, col: 2'd3};
      4'hE: pos = '{row: 2'd3, col: 2'd0};
      4'h0: pos = '{row: 2'd3, col: 2'd1};
      4'hF: pos = '{row: 2'd3, col: 2'd2};
      default: pos = '{row: 2'd3, col: 2'd3};  // 4'hD
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/keypad_responder_bounce_lfsr.sv
// Purpose : free-running 8-bit Fibonacci LFSR that supplies contact chatter.
// Latency : new bit every cycle; output is the registered lfsr[0].
// Backpr. : none, advances unconditionally.
// Ports   : clk, rst_n (async active-low, reloads the seed), bounce_bit out.
module bounce_lfsr
  import keypad_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic bounce_bit
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bounce_bit = lfsr_q[0];

endmodule

// File: rtl/keypad_responder.sv
// Purpose : keypad matrix model; presses a requested key with bounce/hold/release/gap.
// Latency : contact changes the cycle after acceptance; rows->columns is combinational.
// Backpr. : req_ready low (requests ignored) from acceptance until the gap has ended.
// Ports   : clk, reset (async active-low), req_valid/req_key/req_ready request handshake,
//           rows (active-high drive, rows[3]=row 0), columns (active-low sense,
//           columns[3]=col 0), busy, done (one-cycle pulse on sequence completion).
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 64,
  parameter int GAP_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic       busy,
  output logic       done
);

  localparam int MAX_BH  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The counter holds "cycles left after this one", so a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] B_LOAD = (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] H_LOAD = (HOLD_CYCLES > 0)   ? CNT_W'(HOLD_CYCLES - 1)   : '0;
  localparam logic [CNT_W-1:0] G_LOAD = (GAP_CYCLES > 0)    ? CNT_W'(GAP_CYCLES - 1)    : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_pos_t         pos_q, pos_d;
  logic             contact_q, contact_d;
  logic             done_q, done_d;
  logic             bounce_bit;

  bounce_lfsr u_lfsr (
    .clk       (clk),
    .rst_n     (reset),
    .bounce_bit(bounce_bit)
  );

  // Next-state logic. Zero-length bounce/gap phases are skipped outright.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pos_d = key_to_pos(req_key);
          if (BOUNCE_CYCLES > 0) begin
            state_d = ST_PRESS_BOUNCE;
            cnt_d   = B_LOAD;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = H_LOAD;
          end
        end
      end
      ST_PRESS_BOUNCE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = H_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          if (BOUNCE_CYCLES > 0) begin
            state_d = ST_REL_BOUNCE;
            cnt_d   = B_LOAD;
          end else if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = G_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_REL_BOUNCE: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = G_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Contact is registered from the state being entered, so it lines up with that state.
    case (state_d)
      ST_PRESS_BOUNCE, ST_REL_BOUNCE: contact_d = bounce_bit;
      ST_HOLD:                        contact_d = 1'b1;
      default:                        contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pos_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  // Other driven rows do not mask the target row; only its own row bit matters.
  always_comb begin
    columns = COLS_IDLE;
    if (contact_q && rows[2'd3 - pos_q.row]) begin
      columns[2'd3 - pos_q.col] = 1'b0;
    end
  end

endmodule
